// File: rtl/button_manager.sv
// rtl/button_manager.sv - AHB-Lite button peripheral: sync, debounce, press/long-press flags
module button_manager #(
    parameter int DEBOUNCE_CYCLES = 655,
    parameter int LONG_CYCLES     = 32768,
    parameter int CNT_WIDTH       = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        nMode,
    input  logic        nTrip
);

    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_SET = CNT_WIDTH'(LONG_CYCLES - 2);
    localparam logic [CNT_WIDTH-1:0] LONG_MAX = CNT_WIDTH'(LONG_CYCLES);

    // Bit 0 is Mode, bit 1 is Trip throughout.
    logic [1:0]                sync1_q, sync2_q;
    logic [1:0]                level;
    logic [1:0]                stable_q, stable_d, stable_prev_q;
    logic [1:0][CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_WIDTH-1:0]      long_cnt_q, long_cnt_d;
    logic                      mode_press_q, mode_press_d;
    logic                      trip_press_q, trip_press_d;
    logic                      mode_long_q, mode_long_d;
    logic [1:0]                addr_q;
    logic                      read_q, write_q;
    logic                      addr_phase;
    logic [1:0]                press_rise;
    logic                      long_hit;
    logic                      unused_bits;

    assign level       = ~sync2_q;
    assign addr_phase  = HSEL && HREADY && (HTRANS != 2'b00);
    assign press_rise  = stable_q & ~stable_prev_q;
    assign long_hit    = stable_q[0] && (long_cnt_q == LONG_SET);
    assign HREADYOUT   = 1'b1;
    assign unused_bits = ^{HWDATA, HSIZE, HADDR[31:4], HADDR[1:0], write_q};

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (level[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = level[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        long_cnt_d = '0;
        if (stable_q[0]) begin
            long_cnt_d = (long_cnt_q == LONG_MAX) ? long_cnt_q : long_cnt_q + CNT_WIDTH'(1);
        end
    end

    // A set in the same cycle as a clear-on-read wins, so no event is lost.
    always_comb begin
        mode_press_d = press_rise[0] | (mode_press_q & ~(read_q && addr_q == 2'd0));
        trip_press_d = press_rise[1] | (trip_press_q & ~(read_q && addr_q == 2'd1));
        mode_long_d  = long_hit      | (mode_long_q  & ~(read_q && addr_q == 2'd2));
    end

    always_comb begin
        HRDATA = '0;
        if (read_q) begin
            case (addr_q)
                2'd0:    HRDATA[0]   = mode_press_q;
                2'd1:    HRDATA[0]   = trip_press_q;
                2'd2:    HRDATA[0]   = mode_long_q;
                default: HRDATA[1:0] = stable_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q       <= 2'b11;
            sync2_q       <= 2'b11;
            stable_q      <= 2'b00;
            stable_prev_q <= 2'b00;
            db_cnt_q      <= '0;
            long_cnt_q    <= '0;
            mode_press_q  <= 1'b0;
            trip_press_q  <= 1'b0;
            mode_long_q   <= 1'b0;
            addr_q        <= 2'd0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
        end else begin
            sync1_q       <= {nTrip, nMode};
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
            long_cnt_q    <= long_cnt_d;
            mode_press_q  <= mode_press_d;
            trip_press_q  <= trip_press_d;
            mode_long_q   <= mode_long_d;
            if (addr_phase) begin
                addr_q  <= HADDR[3:2];
                read_q  <= !HWRITE;
                write_q <= HWRITE;
            end else begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_manager.sv
// tb/tb_button_manager.sv - directed bench for button_manager with DEBOUNCE_CYCLES=4, LONG_CYCLES=16
module tb_button_manager;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        nMode;
    logic        nTrip;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    button_manager #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16),
        .CNT_WIDTH      (16)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HWRITE   (HWRITE),
        .HREADY   (HREADY),
        .HSEL     (HSEL),
        .HSIZE    (HSIZE),
        .HTRANS   (HTRANS),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .nMode    (nMode),
        .nTrip    (nTrip)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // Address phase on the next edge; returns data-phase HRDATA. Consumes one edge.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = a;
        @(posedge HCLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        d      = HRDATA;
    endtask

    task automatic read_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(nm, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = a;
        @(posedge HCLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = wd;
        check("write_data_phase_hrdata", HRDATA, 32'h0);
        @(posedge HCLK);
        #1;
        HWDATA = 32'h0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
            check({vecs[i].name, "_hreadyout"}, {31'b0, HREADYOUT}, 32'h1);
        end
    endtask

    initial begin
        vecs[0] = '{"rst_mode_press", 32'h0, 32'h0};
        vecs[1] = '{"rst_trip_press", 32'h4, 32'h0};
        vecs[2] = '{"rst_mode_long",  32'h8, 32'h0};
        vecs[3] = '{"rst_stable",     32'hC, 32'h0};
        vecs[4] = '{"press_mode_set",   32'h0, 32'h1};
        vecs[5] = '{"press_mode_clear", 32'h0, 32'h0};
        vecs[6] = '{"press_stable",     32'hC, 32'h1};

        HRESETn = 1'b0;
        HADDR   = 32'h0;
        HWDATA  = 32'h0;
        HWRITE  = 1'b0;
        HREADY  = 1'b1;
        HSEL    = 1'b0;
        HSIZE   = 3'b010;
        HTRANS  = 2'b00;
        nMode   = 1'b1;
        nTrip   = 1'b1;
        idle(3);
        HRESETn = 1'b1;
        check("idle_hrdata", HRDATA, 32'h0);
        run_vecs(0, 3);

        // Mode press: flag set on the 7th edge after the input drop
        nMode = 1'b0;
        idle(6);
        run_vecs(4, 6);
        idle(10);
        read_check("long_before_set", 32'h8, 32'h0);
        read_check("long_set",        32'h8, 32'h1);
        read_check("long_cleared",    32'h8, 32'h0);
        idle(10);
        read_check("long_no_reset_while_held", 32'h8, 32'h0);
        read_check("mode_no_repeat_press",     32'h0, 32'h0);
        read_check("mode_still_stable",        32'hC, 32'h1);

        nMode = 1'b1;
        idle(10);
        read_check("mode_released_stable", 32'hC, 32'h0);
        nMode = 1'b0;
        idle(10);
        nMode = 1'b1;
        idle(10);
        read_check("short_repress_no_long", 32'h8, 32'h0);
        bus_write(32'h0, 32'hFFFF_FFFF);
        read_check("write_keeps_press", 32'h0, 32'h1);
        read_check("press_after_write_cleared", 32'h0, 32'h0);

        // Trip glitches shorter than the debounce window
        for (int r = 0; r < 3; r++) begin
            nTrip = 1'b0;
            idle(3);
            nTrip = 1'b1;
            idle(3);
        end
        read_check("glitch_trip_press",  32'h4, 32'h0);
        read_check("glitch_trip_stable", 32'hC, 32'h0);

        // Read whose clear lands on the same edge as the Trip set
        nTrip = 1'b0;
        idle(5);
        read_check("trip_same_edge_old", 32'h4, 32'h0);
        read_check("trip_set_survives",  32'h4, 32'h1);
        read_check("trip_then_cleared",  32'h4, 32'h0);
        read_check("trip_stable",        32'hC, 32'h2);

        // Reset mid-press with both buttons held
        nMode = 1'b0;
        idle(8);
        HRESETn = 1'b0;
        idle(2);
        check("in_reset_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        read_check("post_rst_mode_press", 32'h0, 32'h0);
        read_check("post_rst_trip_press", 32'h4, 32'h0);
        read_check("post_rst_mode_long",  32'h8, 32'h0);
        read_check("post_rst_stable",     32'hC, 32'h0);
        idle(2);
        read_check("held_through_reset_press", 32'h0, 32'h1);
        read_check("held_through_reset_stable", 32'hC, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_manager.md
Name: button_manager

Overview:
- AHB-Lite slave on the cycle-computer bus. It is the input-side peripheral: the CPU reads it, where the display block is written by the CPU.
- Synchronises and debounces the two active-low push buttons (Mode, Trip).
- Latches press events and a Mode long-press event into sticky flags. Each flag clears when the CPU reads it.
- Zero-wait-state; the CPU polls it.

Parameters:
DEBOUNCE_CYCLES, 655, consecutive stable HCLK cycles needed to accept a level change (about 20 ms at 32.768 kHz)
LONG_CYCLES, 32768, HCLK cycles the debounced Mode press must be held to raise the long-press flag
CNT_WIDTH, 16, width of the debounce and long-press counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES)

Ports:
HCLK  input  1  system clock, the single clock domain
HRESETn  input  1  asynchronous active-low reset
HADDR  input  32  AHB address; only HADDR[3:2] is decoded
HWDATA  input  32  AHB write data; ignored
HWRITE  input  1  AHB write strobe
HREADY  input  1  bus ready
HSEL  input  1  slave select
HSIZE  input  3  transfer size; ignored
HTRANS  input  2  transfer type; IDLE = 2'b00
HRDATA  output  32  read data
HREADYOUT  output  1  tied 1
nMode  input  1  Mode button, active low, asynchronous
nTrip  input  1  Trip button, active low, asynchronous

Behaviour:
- Clock and reset: single clock HCLK. Asynchronous active-low HRESETn.
- Reset values:
  - All flags 0.
  - Stable levels = released.
  - Counters 0.
  - Sync flops = 1 (released).
  - Registered address/read/write = 0.
  - HRDATA = 0.
- Register map, word offsets. All unused bits read 0.
  - 0x0: bit0 ModePress. Clear on read.
  - 0x4: bit0 TripPress. Clear on read.
  - 0x8: bit0 ModeLong. Clear on read.
  - 0xC: bit0 ModeStable, bit1 TripStable. Debounced levels, 1 = pressed. Not cleared by reads.
- AHB address phase:
  - Accepted when HSEL && HREADY && HTRANS != 2'b00.
  - At that edge register Addr_Reg <= HADDR[3:2], Read <= !HWRITE, Write <= HWRITE.
  - Otherwise Read and Write are 0.
  - Writes have no effect. No error response.
- AHB data phase:
  - HRDATA is combinational from Addr_Reg and current register contents while Read = 1; otherwise 0.
  - The cycle after an accepted read address phase, the targeted clear-on-read flag clears at the closing edge.
  - Back-to-back reads are supported.
- Synchroniser: two flops per button (nMode, nTrip), inverted to active-high after synchronisation.
- Debounce, per button:
  - If the synchronised level equals the stable level, the counter resets to 0.
  - Otherwise the counter increments.
  - At the edge where the counter == DEBOUNCE_CYCLES-1 and the level still differs, the stable level takes the new value and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count and never changes the stable level.
- Event detection:
  - A rising edge of the stable level (released -> pressed) sets the Press flag at the next edge.
  - Latency from a clean input transition to a readable flag: DEBOUNCE_CYCLES+3 HCLK edges.
  - Release edges set nothing.
- Long press:
  - Counter runs while ModeStable = 1 and saturates at LONG_CYCLES.
  - ModeLong is set exactly once, at the edge the count reaches LONG_CYCLES-1.
  - The counter resets when ModeStable = 0.
  - ModePress still sets on the original press edge.
- Simultaneous events:
  - If a set and a clear-on-read hit the same flag in the same cycle, set wins and the flag stays 1. The CPU sees it on the next read.
  - Multiple presses before a read collapse into a single flag. There is no counting.
- Reset mid-press: all state returns to released. A button held through reset release is seen as a new press after DEBOUNCE_CYCLES+3 edges.

Test Plan:
- Parameters for all tests: DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
- Reset, then read 0x0, 0x4, 0x8, 0xC -> all return 0. HREADYOUT = 1 throughout.
- Drive nMode low and hold it. Read 0x0 after 7 edges -> 1. Read 0x0 again -> 0. Read 0xC -> 0x1.
- Pulse nTrip low for 3 cycles, repeated -> TripPress stays 0 and 0xC bit1 stays 0. Glitch is rejected.
- Hold nMode low for 30 cycles:
  - 0x8 reads 1 once. A second read gives 0.
  - No further set while held.
  - Release and re-press for 10 cycles -> 0x8 stays 0.
- Write 0xFFFFFFFF to 0x0 while ModePress = 1 -> the flag is unchanged. Read -> 1.
- Time a read of 0x4 whose data-phase clear lands on the same edge as a new Trip rising edge -> that read returns the old value. The flag remains 1. The next read -> 1, then 0.
- Assert HRESETn low mid-press with flags set -> all reads return 0 after reset. Holding nMode low through reset gives ModePress = 1 after 7 edges.
